// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: EX-stage hazard and sequencing controller.
// Produces operand forwarding selects, load-use bubbles, branch flushes and a
// countdown hold that keeps a multi-cycle op in EX for MULTI_CYCLES cycles.
// Optional feature macro: FORWARDING_EN. When it is undefined, forwarding is
// disabled and RAW hazards on in-flight writers are resolved by stalling.
module hazard_stall_ctrl #(
  parameter int MULTI_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_if_id_rs,
  input  logic [4:0] i_if_id_rt,
  input  logic [4:0] i_id_ex_rs,
  input  logic [4:0] i_id_ex_rt,
  input  logic [4:0] i_id_ex_rd,
  input  logic       i_id_ex_reg_write,
  input  logic       i_id_ex_mem_read,
  input  logic       i_id_ex_multi,
  input  logic [4:0] i_ex_mem_rd,
  input  logic [4:0] i_mem_wb_rd,
  input  logic       i_ex_mem_reg_write,
  input  logic       i_mem_wb_reg_write,
  input  logic       i_branch_taken,
  output logic [1:0] o_forward_a,
  output logic [1:0] o_forward_b,
  output logic       o_pc_write,
  output logic       o_if_id_write,
  output logic       o_if_id_flush,
  output logic       o_id_ex_write,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_flush,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(MULTI_CYCLES + 1);
  // Entry cycle counts as the first occupancy cycle, release as the last.
  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(MULTI_CYCLES - 2);
  localparam logic [CNT_W-1:0] LP_ZERO   = {CNT_W{1'b0}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_load_use;
  logic       w_raw_stall;
  logic       w_stall;

  assign w_load_use = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                      ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

`ifdef FORWARDING_EN
  // EX/MEM result is newer than MEM/WB data, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ex_mem_rd,
    input logic       ex_mem_we,
    input logic [4:0] mem_wb_rd,
    input logic       mem_wb_we
  );
    if (ex_mem_we && (ex_mem_rd != 5'd0) && (ex_mem_rd == src)) begin
      return 2'b10;
    end else if (mem_wb_we && (mem_wb_rd != 5'd0) && (mem_wb_rd == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign w_fwd_a     = fwd_sel(i_id_ex_rs, i_ex_mem_rd, i_ex_mem_reg_write,
                               i_mem_wb_rd, i_mem_wb_reg_write);
  assign w_fwd_b     = fwd_sel(i_id_ex_rt, i_ex_mem_rd, i_ex_mem_reg_write,
                               i_mem_wb_rd, i_mem_wb_reg_write);
  assign w_raw_stall = 1'b0;
`else
  logic w_id_ex_hit;
  logic w_ex_mem_hit;
  logic w_unused_fwd_inputs;

  // Without bypass paths the ID instruction waits until its writer is in WB.
  assign w_id_ex_hit  = i_id_ex_reg_write && (i_id_ex_rd != 5'd0) &&
                        ((i_id_ex_rd == i_if_id_rs) || (i_id_ex_rd == i_if_id_rt));
  assign w_ex_mem_hit = i_ex_mem_reg_write && (i_ex_mem_rd != 5'd0) &&
                        ((i_ex_mem_rd == i_if_id_rs) || (i_ex_mem_rd == i_if_id_rt));
  assign w_raw_stall  = w_id_ex_hit || w_ex_mem_hit;
  assign w_fwd_a      = 2'b00;
  assign w_fwd_b      = 2'b00;
  assign w_unused_fwd_inputs = ^{i_id_ex_rs, i_mem_wb_rd, i_mem_wb_reg_write};
`endif

  assign w_stall = w_load_use || w_raw_stall;

  // State and countdown register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= LP_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and output decode: reset > multi hold/entry > branch > stall.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    o_forward_a    = w_fwd_a;
    o_forward_b    = w_fwd_b;
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_write  = 1'b1;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_busy         = 1'b0;
    if (i_rst) begin
      w_state_nxt    = ST_IDLE;
      w_cnt_nxt      = LP_ZERO;
      o_forward_a    = 2'b00;
      o_forward_b    = 2'b00;
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_write  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_flush = 1'b1;
      o_busy         = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_id_ex_multi) begin
            w_state_nxt    = ST_MULTI;
            w_cnt_nxt      = LP_RELOAD;
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_write  = 1'b0;
            o_ex_mem_flush = 1'b1;
            o_busy         = 1'b1;
          end else if (i_branch_taken) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
          end else if (w_stall) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_flush  = 1'b1;
          end else begin
            o_busy         = 1'b0;
          end
        end
        ST_MULTI: begin
          if (r_cnt != LP_ZERO) begin
            w_cnt_nxt      = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_write  = 1'b0;
            o_ex_mem_flush = 1'b1;
            o_busy         = 1'b1;
          end else begin
            // Release: the held op's result enters EX/MEM this cycle.
            w_state_nxt    = ST_IDLE;
            w_cnt_nxt      = LP_ZERO;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = LP_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl plus multi-cycle sequences.
module tb_hazard_stall_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {fa[1:0], fb[1:0], pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_f, busy}
  localparam logic [10:0] E_IDLE  = 11'b00_00_1_1_0_1_0_0_0;
  localparam logic [10:0] E_STALL = 11'b00_00_0_0_0_1_1_0_0;
  localparam logic [10:0] E_BR    = 11'b00_00_1_1_1_1_1_0_0;
  localparam logic [10:0] E_HOLD  = 11'b00_00_0_0_0_0_0_1_1;
  localparam logic [10:0] E_RST   = 11'b00_00_0_0_1_1_1_1_0;
  localparam logic [10:0] FA_EXM  = 11'b10_00_0_0_0_0_0_0_0;
  localparam logic [10:0] FA_WB   = 11'b01_00_0_0_0_0_0_0_0;
  localparam logic [10:0] FB_EXM  = 11'b00_10_0_0_0_0_0_0_0;
  localparam logic [10:0] FB_WB   = 11'b00_01_0_0_0_0_0_0_0;

  typedef struct {
    logic [4:0]  if_rs, if_rt, ex_rs, ex_rt, ex_rd;
    logic        ex_rw, ex_mr;
    logic [4:0]  mem_rd;
    logic        mem_rw;
    logic [4:0]  wb_rd;
    logic        wb_rw, br;
    logic [10:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rs, id_ex_rt, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic id_ex_reg_write, id_ex_mem_read, id_ex_multi;
  logic ex_mem_reg_write, mem_wb_reg_write, branch_taken;
  logic [1:0] fa, fb;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, busy;
  logic [10:0] outv;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vecs[13];

  hazard_stall_ctrl #(.MULTI_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_id_rs(if_id_rs), .i_if_id_rt(if_id_rt),
    .i_id_ex_rs(id_ex_rs), .i_id_ex_rt(id_ex_rt), .i_id_ex_rd(id_ex_rd),
    .i_id_ex_reg_write(id_ex_reg_write), .i_id_ex_mem_read(id_ex_mem_read),
    .i_id_ex_multi(id_ex_multi),
    .i_ex_mem_rd(ex_mem_rd), .i_mem_wb_rd(mem_wb_rd),
    .i_ex_mem_reg_write(ex_mem_reg_write), .i_mem_wb_reg_write(mem_wb_reg_write),
    .i_branch_taken(branch_taken),
    .o_forward_a(fa), .o_forward_b(fb),
    .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_if_id_flush(if_id_flush),
    .o_id_ex_write(id_ex_write), .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_flush(ex_mem_flush), .o_busy(busy)
  );

  assign outv = {fa, fb, pc_write, if_id_write, if_id_flush, id_ex_write,
                 id_ex_flush, ex_mem_flush, busy};

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] if_rs, if_rt, ex_rs, ex_rt, ex_rd,
                              input logic ex_rw, ex_mr,
                              input logic [4:0] mem_rd, input logic mem_rw,
                              input logic [4:0] wb_rd, input logic wb_rw, br,
                              input logic [10:0] exp);
    vec_t v;
    v.if_rs = if_rs; v.if_rt = if_rt; v.ex_rs = ex_rs; v.ex_rt = ex_rt; v.ex_rd = ex_rd;
    v.ex_rw = ex_rw; v.ex_mr = ex_mr; v.mem_rd = mem_rd; v.mem_rw = mem_rw;
    v.wb_rd = wb_rd; v.wb_rw = wb_rw; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    if_id_rs = v.if_rs; if_id_rt = v.if_rt;
    id_ex_rs = v.ex_rs; id_ex_rt = v.ex_rt; id_ex_rd = v.ex_rd;
    id_ex_reg_write = v.ex_rw; id_ex_mem_read = v.ex_mr;
    ex_mem_rd = v.mem_rd; ex_mem_reg_write = v.mem_rw;
    mem_wb_rd = v.wb_rd; mem_wb_reg_write = v.wb_rw;
    branch_taken = v.br;
  endtask

  task automatic clear_inputs();
    apply(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE));
    id_ex_multi = 1'b0;
  endtask

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b required %b", nm, act, exp);
    else n_pass++;
  endtask

  // Drive inputs just after the falling edge, sample 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    clear_inputs();

    // Table: if_rs if_rt ex_rs ex_rt ex_rd ex_rw ex_mr mem_rd mem_rw wb_rd wb_rw br exp
    vecs[0]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    vecs[1]  = mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0,
                  FWD ? (E_IDLE | FA_EXM) : E_IDLE);
    vecs[2]  = mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0,
                  FWD ? (E_IDLE | FA_WB) : E_IDLE);
    vecs[3]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, E_IDLE);
    vecs[4]  = mk(5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0,
                  FWD ? (E_IDLE | FB_WB) : E_IDLE);
    vecs[5]  = mk(5'd0, 5'd8, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_STALL);
    vecs[6]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    vecs[7]  = mk(5'd0, 5'd8, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, E_BR);
    vecs[8]  = mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                  FWD ? E_IDLE : E_STALL);
    vecs[9]  = mk(5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0,
                  FWD ? E_IDLE : E_STALL);
    vecs[10] = mk(5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, E_IDLE);
    vecs[11] = mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE);
    vecs[12] = mk(5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0,
                  FWD ? (E_IDLE | FA_EXM | FB_EXM) : E_IDLE);

    // Reset: outputs forced while rst is high.
    step(); #1 check("reset_outputs", outv, E_RST);
    step(); rst = 1'b0;
    #1 check("after_reset_idle", outv, E_IDLE);

    foreach (vecs[i]) begin
      step(); apply(vecs[i]);
      #1 check($sformatf("vec%0d", i), outv, vecs[i].exp);
    end

    // Multi-cycle op: 3 hold cycles, release on the 4th, IDLE on the 5th.
    step(); clear_inputs(); id_ex_multi = 1'b1;
    #1 check("multi_c1_entry", outv, E_HOLD);
    step(); id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rt = 5'd8;
    #1 check("multi_c2_hold_ignores_loaduse", outv, E_HOLD);
    step(); branch_taken = 1'b1;
    #1 check("multi_c3_hold_ignores_branch", outv, E_HOLD);
    step(); branch_taken = 1'b0;
    #1 check("multi_c4_release", outv, E_STALL & 11'b0 | E_IDLE);
    step(); id_ex_multi = 1'b0;
    #1 check("multi_c5_idle_loaduse", outv, E_STALL);

    // Reset in the second multi cycle aborts the op.
    step(); clear_inputs(); id_ex_multi = 1'b1;
    #1 check("abort_c1_entry", outv, E_HOLD);
    step(); rst = 1'b1;
    #1 check("abort_c2_reset", outv, E_RST);
    step(); rst = 1'b0; id_ex_multi = 1'b0;
    #1 check("abort_c3_idle", outv, E_IDLE);
    step(); branch_taken = 1'b1;
    #1 check("abort_c4_branch", outv, E_BR);

    // A fresh op after the abort still takes the full occupancy.
    step(); clear_inputs(); id_ex_multi = 1'b1;
    #1 check("rerun_c1_entry", outv, E_HOLD);
    step(); step();
    #1 check("rerun_c3_hold", outv, E_HOLD);
    step();
    #1 check("rerun_c4_release", outv, E_IDLE);

    // Writer moves EX -> MEM -> WB while the ID instruction reads r3.
    step(); clear_inputs(); if_id_rs = 5'd3; id_ex_rd = 5'd3; id_ex_reg_write = 1'b1;
    #1 check("raw_c1", outv, FWD ? E_IDLE : E_STALL);
    step(); id_ex_rd = 5'd0; id_ex_reg_write = 1'b0; ex_mem_rd = 5'd3; ex_mem_reg_write = 1'b1;
    #1 check("raw_c2", outv, FWD ? E_IDLE : E_STALL);
    step(); ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b0; mem_wb_rd = 5'd3; mem_wb_reg_write = 1'b1;
    #1 check("raw_c3_writer_in_wb", outv, E_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
